// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM fetch front end.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package arm_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'd0;

    typedef enum logic [1:0] {
        RESET_ST = 2'd0,
        FETCH    = 2'd1,
        STALL    = 2'd2,
        REDIRECT = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instru;
        logic [ADDR_W-1:0]  pc_plus4;
    } fetch_entry_t;

    // Instructions are word aligned; a redirect target's low two bits are dropped.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: DEPTH-entry FIFO of {instruction, pc+4} with flush.
// Latency: an entry pushed on edge N is visible at the head in the following cycle.
// Backpressure: caller must not push when full unless it pops the same cycle; flush overrides push/pop.
module fetch_queue
    import arm_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t wr_dat_i,
    output fetch_entry_t rd_dat_o,
    output logic         rd_vld_o,
    output logic         full_o
);
    // DEPTH is 2 or 4, so pointers wrap naturally at their bit width.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fetch_entry_t     mem_q [DEPTH];

    assign rd_vld_o = (count_q != '0);
    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign rd_dat_o = rd_vld_o ? mem_q[rd_ptr_q] : '0;

    // Pointer and occupancy update; a flush empties the queue regardless of push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state; reset discards contents by zeroing the occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful under count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wr_dat_i;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives imem, feeds decode from a prefetch queue.
// Latency: word fetched in cycle N is at out_* in cycle N+1; a branch costs one bubble cycle.
// Backpressure: out_ready low fills the queue, then PC and pushes hold; a branch flush always wins.
module fetch_ctrl
    import arm_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instru,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instru,
    output logic [ADDR_W-1:0]  out_pc_plus4
);
    logic [ADDR_W-1:0] pc_q, pc_d, pc_plus4;
    logic              pop, push, q_full, q_vld;
    fetch_entry_t      wr_entry, head;
    fetch_state_e      state_q, state_d;

    // imem sees the PC register only, so no input reaches the memory address combinationally.
    assign imem_addr = pc_q;
    assign pc_plus4  = pc_q + ADDR_W'(4);

    // A full queue may still accept a word when decode drains the head in the same cycle.
    assign pop  = q_vld & out_ready;
    assign push = en & ~branch_taken & (~q_full | pop);

    assign wr_entry.instru   = imem_instru;
    assign wr_entry.pc_plus4 = pc_plus4;

    // Next PC: a redirect beats everything, otherwise only an actual push advances it.
    always_comb begin
        pc_d = pc_q;
        if (branch_taken) pc_d = word_align(branch_addr);
        else if (push)    pc_d = pc_plus4;
    end

    // Sequencer state: tracks whether fetch is streaming, stalled, or recovering from a redirect.
    always_comb begin
        state_d = state_q;
        if (branch_taken) begin
            state_d = REDIRECT;
        end else begin
            case (state_q)
                RESET_ST: state_d = FETCH;
                REDIRECT: state_d = en ? FETCH : STALL;
                FETCH:    state_d = (!en || (q_full && !pop)) ? STALL : FETCH;
                STALL:    state_d = push ? FETCH : STALL;
                default:  state_d = RESET_ST;
            endcase
        end
    end

    // PC and sequencer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= RESET_ST;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (branch_taken),
        .push_i   (push),
        .pop_i    (pop),
        .wr_dat_i (wr_entry),
        .rd_dat_o (head),
        .rd_vld_o (q_vld),
        .full_o   (q_full)
    );

    assign out_valid    = q_vld;
    assign out_instru   = head.instru;
    assign out_pc_plus4 = head.pc_plus4;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic against a queue-based model.
// Latency: model predicts outputs each cycle before the edge, then advances on the edge.
// Backpressure: out_ready, en and branch_taken are driven directly by each scenario.
module tb_fetch_ctrl;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc4;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        branch_taken = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] branch_addr = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instru;
    logic        out_valid;
    logic [31:0] out_instru;
    logic [31:0] out_pc_plus4;

    logic [31:0] imem [64];
    ent_t        mq [$];
    logic [31:0] mpc;
    int          n_cmp = 0;
    int          n_err = 0;

    assign imem_instru = imem[imem_addr[7:2]];

    always #5 clk = ~clk;

    fetch_ctrl #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'd0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_addr    (imem_addr),
        .imem_instru  (imem_instru),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instru   (out_instru),
        .out_pc_plus4 (out_pc_plus4)
    );

    // Expected {out_valid, out_instru, out_pc_plus4, imem_addr} from the model.
    function automatic logic [96:0] exp_bus();
        if (mq.size() == 0) return {1'b0, 32'd0, 32'd0, mpc};
        return {1'b1, mq[0].ins, mq[0].pc4, mpc};
    endfunction

    function automatic logic [96:0] obs_bus();
        return {out_valid, out_instru, out_pc_plus4, imem_addr};
    endfunction

    // Called just after a rising edge: drive inputs, then wait to the falling edge.
    task automatic apply(input logic e, input logic r, input logic b, input logic [31:0] a);
        en = e;
        out_ready = r;
        branch_taken = b;
        branch_addr = a;
        @(negedge clk);
    endtask

    // Advance the model by one clock according to the current inputs, then cross the edge.
    task automatic advance();
        int  sz;
        logic did_pop;
        sz = mq.size();
        did_pop = (sz != 0) && out_ready;
        if (branch_taken) begin
            mq.delete();
            mpc = {branch_addr[31:2], 2'b00};
        end else begin
            if (did_pop) void'(mq.pop_front());
            if (en && (sz < DEPTH || did_pop)) begin
                mq.push_back('{ins: imem[mpc[7:2]], pc4: mpc + 32'd4});
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        out_ready = 1'b0;
        branch_taken = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        mpc = 32'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        out_ready = 1'b1;
        #2;
        n_cmp++;
        if (obs_bus() !== 97'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want %h", obs_bus(), 97'd0);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs_bus() !== 97'd0) begin
            n_err++;
            $display("FAIL reset_held_over_edge: got %h want %h", obs_bus(), 97'd0);
        end
        rst_n = 1'b1;
        mq.delete();
        mpc = 32'd0;
    endtask

    task automatic test_stream();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            apply(1'b1, 1'b1, 1'b0, 32'd0);
            n_cmp++;
            if (obs_bus() !== exp_bus()) begin
                n_err++;
                $display("FAIL stream_c%0d: got %h want %h", c, obs_bus(), exp_bus());
            end
            if (c == 1) begin
                n_cmp++;
                if ({out_valid, out_instru, out_pc_plus4} !== {1'b1, 32'hE3A00014, 32'd4}) begin
                    n_err++;
                    $display("FAIL stream_first: got %b %h %h want 1 e3a00014 00000004",
                             out_valid, out_instru, out_pc_plus4);
                end
            end
            if (c == 2) begin
                n_cmp++;
                if ({out_instru, out_pc_plus4} !== {32'hE3A01A01, 32'd8}) begin
                    n_err++;
                    $display("FAIL stream_second: got %h %h want e3a01a01 00000008",
                             out_instru, out_pc_plus4);
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            apply(1'b1, 1'b0, 1'b0, 32'd0);
            n_cmp++;
            if (obs_bus() !== exp_bus()) begin
                n_err++;
                $display("FAIL bp_hold_c%0d: got %h want %h", c, obs_bus(), exp_bus());
            end
            if (c == 4) begin
                n_cmp++;
                if ({imem_addr, out_instru} !== {32'd8, 32'hE3A00014}) begin
                    n_err++;
                    $display("FAIL bp_stuck: got addr %h instru %h want 00000008 e3a00014",
                             imem_addr, out_instru);
                end
            end
            advance();
        end
        for (int c = 0; c < 6; c++) begin
            apply(1'b1, 1'b1, 1'b0, 32'd0);
            n_cmp++;
            if (obs_bus() !== exp_bus()) begin
                n_err++;
                $display("FAIL bp_drain_c%0d: got %h want %h", c, obs_bus(), exp_bus());
            end
            if (c < 3) begin
                n_cmp++;
                if (out_pc_plus4 !== 32'd4 * (c + 1)) begin
                    n_err++;
                    $display("FAIL bp_order_c%0d: got %h want %h", c, out_pc_plus4, 32'd4 * (c + 1));
                end
            end
            advance();
        end
    endtask

    task automatic test_branch();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            apply(1'b1, 1'b0, 1'b0, 32'd0);
            n_cmp++;
            if (obs_bus() !== exp_bus()) begin
                n_err++;
                $display("FAIL br_fill_c%0d: got %h want %h", c, obs_bus(), exp_bus());
            end
            advance();
        end
        apply(1'b1, 1'b0, 1'b1, 32'h40);
        advance();
        apply(1'b1, 1'b1, 1'b0, 32'd0);
        n_cmp++;
        if ({out_valid, imem_addr} !== {1'b0, 32'h40}) begin
            n_err++;
            $display("FAIL br_bubble: got valid %b addr %h want 0 00000040", out_valid, imem_addr);
        end
        advance();
        apply(1'b1, 1'b1, 1'b0, 32'd0);
        n_cmp++;
        if ({out_valid, out_instru, out_pc_plus4} !== {1'b1, 32'hE3A00B01, 32'h44}) begin
            n_err++;
            $display("FAIL br_target: got %b %h %h want 1 e3a00b01 00000044",
                     out_valid, out_instru, out_pc_plus4);
        end
        advance();
        apply(1'b1, 1'b1, 1'b1, 32'h43);
        advance();
        apply(1'b1, 1'b1, 1'b0, 32'd0);
        n_cmp++;
        if (imem_addr !== 32'h40) begin
            n_err++;
            $display("FAIL br_mask: got %h want 00000040", imem_addr);
        end
        n_cmp++;
        if (obs_bus() !== exp_bus()) begin
            n_err++;
            $display("FAIL br_mask_model: got %h want %h", obs_bus(), exp_bus());
        end
        advance();
    endtask

    task automatic test_en_low();
        logic [31:0] frozen;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            apply(1'b1, 1'b1, 1'b0, 32'd0);
            advance();
        end
        frozen = mpc;
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 1'b1, 1'b0, 32'd0);
            n_cmp++;
            if (obs_bus() !== exp_bus()) begin
                n_err++;
                $display("FAIL en_low_c%0d: got %h want %h", c, obs_bus(), exp_bus());
            end
            advance();
        end
        apply(1'b1, 1'b1, 1'b0, 32'd0);
        n_cmp++;
        if ({out_valid, imem_addr} !== {1'b0, frozen}) begin
            n_err++;
            $display("FAIL en_low_frozen: got valid %b addr %h want 0 %h", out_valid, imem_addr, frozen);
        end
        advance();
        apply(1'b1, 1'b1, 1'b0, 32'd0);
        n_cmp++;
        if ({out_valid, out_pc_plus4} !== {1'b1, frozen + 32'd4}) begin
            n_err++;
            $display("FAIL en_resume: got valid %b pc4 %h want 1 %h", out_valid, out_pc_plus4, frozen + 32'd4);
        end
        advance();
        apply(1'b0, 1'b1, 1'b1, 32'h20);
        advance();
        apply(1'b0, 1'b1, 1'b0, 32'd0);
        n_cmp++;
        if ({out_valid, imem_addr} !== {1'b0, 32'h20}) begin
            n_err++;
            $display("FAIL en_low_branch: got valid %b addr %h want 0 00000020", out_valid, imem_addr);
        end
        advance();
    endtask

    task automatic test_wrap();
        do_reset();
        apply(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        advance();
        apply(1'b1, 1'b1, 1'b0, 32'd0);
        n_cmp++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL wrap_target: got %h want fffffffc", imem_addr);
        end
        advance();
        apply(1'b1, 1'b1, 1'b0, 32'd0);
        n_cmp++;
        if ({out_valid, out_pc_plus4, imem_addr} !== {1'b1, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL wrap_pc: got valid %b pc4 %h addr %h want 1 00000000 00000000",
                     out_valid, out_pc_plus4, imem_addr);
        end
        n_cmp++;
        if (obs_bus() !== exp_bus()) begin
            n_err++;
            $display("FAIL wrap_model: got %h want %h", obs_bus(), exp_bus());
        end
        advance();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            apply(1'b1, 1'b0, 1'b0, 32'd0);
            advance();
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_instru, imem_addr} !== {1'b0, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL async_reset: got valid %b instru %h addr %h want 0 00000000 00000000",
                     out_valid, out_instru, imem_addr);
        end
        mq.delete();
        mpc = 32'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            apply(1'b1, 1'b1, 1'b0, 32'd0);
            n_cmp++;
            if (obs_bus() !== exp_bus()) begin
                n_err++;
                $display("FAIL async_restart_c%0d: got %h want %h", c, obs_bus(), exp_bus());
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic        e, r, b;
        logic [31:0] a;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            e = ($urandom_range(0, 9) != 0);
            r = ($urandom_range(0, 2) != 0);
            b = ($urandom_range(0, 15) == 0);
            a = $urandom;
            apply(e, r, b, a);
            n_cmp++;
            if (obs_bus() !== exp_bus()) begin
                n_err++;
                $display("FAIL random_c%0d: got %h want %h", c, obs_bus(), exp_bus());
            end
            advance();
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = $urandom;
        imem[0]  = 32'hE3A00014;
        imem[1]  = 32'hE3A01A01;
        imem[16] = 32'hE3A00B01;
        mpc = 32'd0;

        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_en_low();
        test_wrap();
        test_async_reset();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
